// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-cycle N-bit adder that reuses one CHUNK-bit slice,
// adding one chunk per clock behind a start/done handshake.
module add_seq_ctrl #(
   parameter int CHUNK  = 3,
   parameter int NCHUNK = 4,
   parameter int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [CHUNK*NCHUNK-1:0]   a,
   input  logic [CHUNK*NCHUNK-1:0]   b,
   input  logic                      cin,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic [CHUNK*NCHUNK:0]     sum
);
   localparam int N = CHUNK * NCHUNK;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state;
   logic [N-1:0]      op_a, op_b;
   logic              carry;
   logic [IDXW-1:0]   idx;
   logic [CHUNK:0]    slice;
   logic              last;

   assign slice = {1'b0, op_a[idx*CHUNK +: CHUNK]} + {1'b0, op_b[idx*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
   assign last  = idx == IDXW'(NCHUNK - 1);
   assign busy  = state != IDLE;

   // The top carry is written with the last chunk so that done and the full sum line up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  sum[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
                  carry <= slice[CHUNK];
                  if (last) begin
                     sum[N] <= slice[CHUNK];
                     done   <= 1'b1;
                     state  <= FIN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            FIN: begin
               sum[N] <= carry;
               done   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: drives three configurations (3x4, 1x8, 4x1) of add_seq_ctrl
// and compares every result against plain a+b+cin arithmetic.
module tb_add_seq_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cin = 1'b0;
   logic [11:0] a = '0, b = '0;
   logic [12:0] sum0;
   logic [8:0]  sum1;
   logic [4:0]  sum2;
   logic        busy0, busy1, busy2, done0, done1, done2;
   logic [2:0]  bz, dn;
   logic [12:0] sm [3];
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   add_seq_ctrl #(.CHUNK(3), .NCHUNK(4)) dut0 (.clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .cin(cin), .abort(abort), .busy(busy0), .done(done0), .sum(sum0));
   add_seq_ctrl #(.CHUNK(1), .NCHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .start(start),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .abort(abort), .busy(busy1), .done(done1), .sum(sum1));
   add_seq_ctrl #(.CHUNK(4), .NCHUNK(1)) dut2 (.clk(clk), .rst_n(rst_n), .start(start),
      .a(a[3:0]), .b(b[3:0]), .cin(cin), .abort(abort), .busy(busy2), .done(done2), .sum(sum2));

   assign bz    = {busy2, busy1, busy0};
   assign dn    = {done2, done1, done0};
   assign sm[0] = sum0;
   assign sm[1] = {4'b0, sum1};
   assign sm[2] = {8'b0, sum2};

   function automatic int nc(input int k);
      return k == 0 ? 4 : k == 1 ? 8 : 1;
   endfunction

   // Reference: unsigned sum of the low-width operands plus carry-in, no truncation.
   function automatic logic [31:0] ref_sum(input int k, input logic [11:0] x, y, input logic c);
      int w;
      int m;
      w = k == 0 ? 12 : k == 1 ? 8 : 4;
      m = (1 << w) - 1;
      return 32'((int'(x) & m) + (int'(y) & m) + int'(c));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [11:0] x, y, input logic c, input logic [2:0] mask, input bit spam);
      int          lat [3];
      int          cnt [3];
      logic [12:0] got [3];
      for (int k = 0; k < 3; k++) begin
         lat[k] = -1;
         cnt[k] = 0;
         got[k] = '0;
      end
      @(negedge clk);
      a = x; b = y; cin = c; start = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start = spam && n >= 2 && n <= 5;
         a     = spam ? 12'hAAA : 12'($urandom);
         b     = 12'($urandom);
         cin   = 1'($urandom);
         for (int k = 0; k < 3; k++) if (mask[k]) begin
            check($sformatf("busy%0d_c%0d", k, n), 32'(bz[k]), 32'(n <= nc(k) + 1));
            if (dn[k]) begin
               cnt[k]++;
               if (lat[k] < 0) begin
                  lat[k] = n;
                  got[k] = sm[k];
               end
            end
         end
      end
      start = 1'b0;
      for (int k = 0; k < 3; k++) if (mask[k]) begin
         check($sformatf("lat%0d", k), 32'(lat[k]), 32'(nc(k) + 1));
         check($sformatf("ndone%0d", k), 32'(cnt[k]), 32'd1);
         check($sformatf("sum%0d", k), 32'(got[k]), ref_sum(k, x, y, c));
         check($sformatf("hold%0d", k), 32'(sm[k]), ref_sum(k, x, y, c));
      end
   endtask

   task automatic wait_done0(output int n);
      n = 1;
      while (!done0 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nd;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_busy%0d", k), 32'(bz[k]), 32'd0);
         check($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
         check($sformatf("rst_sum%0d", k), 32'(sm[k]), 32'd0);
      end
      rst_n = 1'b1;

      run_op(12'hFFF, 12'h001, 1'b0, 3'b111, 1'b0);
      run_op(12'h123, 12'h456, 1'b1, 3'b111, 1'b0);

      // back-to-back: second start in the idle cycle right after done
      @(negedge clk);
      a = 12'h123; b = 12'h456; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done0(n);
      check("b2b_lat1", 32'(n), 32'd5);
      check("b2b_sum1", 32'(sum0), 32'h057A);
      @(negedge clk);
      check("b2b_idle", 32'(busy0), 32'd0);
      a = 12'h800; b = 12'h800; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy0), 32'd1);
      wait_done0(n);
      check("b2b_lat2", 32'(n), 32'd5);
      check("b2b_sum2", 32'(sum0), 32'h1000);
      repeat (12) @(negedge clk);

      // starts during RUN/FIN must be ignored by the 3x4 instance
      run_op(12'h0F0, 12'h10F, 1'b1, 3'b001, 1'b1);
      repeat (4) @(negedge clk);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      a = 12'hFFF; b = 12'h000; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      check("pre_rst_sum", 32'(sum0), 32'h0007);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy0), 32'd0);
      check("arst_done", 32'(done0), 32'd0);
      check("arst_sum", 32'(sum0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(12'h5A5, 12'h3C3, 1'b1, 3'b111, 1'b0);

      // abort in the second RUN cycle
      @(negedge clk);
      a = 12'hFFF; b = 12'h001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy0), 32'd0);
      nd = int'(done0);
      repeat (6) begin
         @(negedge clk);
         nd += int'(done0);
      end
      check("abort_ndone", 32'(nd), 32'd0);
      run_op(12'h007, 12'h001, 1'b0, 3'b111, 1'b0);
      check("after_abort", 32'(sum0), 32'h0008);

      for (int i = 0; i < 1000; i++)
         run_op(12'($urandom), 12'($urandom), 1'($urandom), 3'b111, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
